xpmwrap_sdpram_fifo_ctrl: RTL and testbench

//  Common-clock FIFO controller driving one xpmwrap_sdpram instance (ASYMETRIC_MODE=0, CLOCKING_MODE=0,

---
 rtl/xpmwrap_sdpram_fifo_ctrl.sv | 144 ++++++++++++++
 tb/tb_xpmwrap_sdpram_fifo_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xpmwrap_sdpram_fifo_ctrl.sv
// rtl/xpmwrap_sdpram_fifo_ctrl.sv - common-clock FIFO controller around a 2-cycle-latency simple dual-port RAM
// Credit-limited reads feed a 4-entry output skid buffer so the read stream sustains 1 word/clk.
module xpmwrap_sdpram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [ADDR_WIDTH+2:0] level,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic                  ram_wea,
  output logic                  ram_ena,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_enb,
  output logic                  ram_regceb,
  output logic                  ram_rstb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  localparam int DEPTH      = 2**ADDR_WIDTH;
  localparam int OBUF_DEPTH = 4;
  localparam int RD_LAT     = 2;
  localparam logic [ADDR_WIDTH:0] RAM_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_s_tready;
  logic [RD_LAT-1:0]     r_vld_pipe;
  logic                  r_cap_pending;
  logic [DATA_WIDTH-1:0] r_cap_data;
  logic [DATA_WIDTH-1:0] r_obuf [OBUF_DEPTH];
  logic [1:0]            r_ob_wr;
  logic [1:0]            r_ob_rd;
  logic [2:0]            r_ob_cnt;
  logic                  r_m_tvalid;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic [ADDR_WIDTH+2:0] r_level;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [2:0]            w_inflight;
  logic [3:0]            w_credit_used;
  logic [ADDR_WIDTH:0]   w_ram_cnt_nxt;
  logic [1:0]            w_ob_rd_nxt;
  logic [2:0]            w_ob_remain;
  logic [2:0]            w_ob_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_push     = s_tvalid & r_s_tready;
  assign w_pop      = r_m_tvalid & m_tready;
  assign w_inflight = 3'($countones(r_vld_pipe)) + 3'(r_cap_pending);

  // A pop this cycle frees its slot for an issue in the same cycle, so the
  // issue-to-pop loop of four cycles runs at one word per clock.
  assign w_credit_used = 4'(r_ob_cnt) + 4'(w_inflight) - 4'(w_pop);
  assign w_issue       = (r_ram_cnt != '0) && (w_credit_used < 4'(OBUF_DEPTH));
  assign w_ram_cnt_nxt = r_ram_cnt + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_issue);

  assign w_ob_rd_nxt  = r_ob_rd + 2'(w_pop);
  assign w_ob_remain  = r_ob_cnt - 3'(w_pop);
  assign w_ob_cnt_nxt = w_ob_remain + 3'(r_cap_pending);

  always_comb begin
    w_head = r_m_tdata;
    if (w_ob_remain != '0) begin
      w_head = r_obuf[w_ob_rd_nxt];
    end else if (r_cap_pending) begin
      w_head = r_cap_data;
    end
  end

  always_ff @(posedge clk) begin
    if (r_cap_pending) begin
      r_obuf[r_ob_wr] <= r_cap_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_ram_cnt     <= '0;
      r_s_tready    <= 1'b0;
      r_vld_pipe    <= '0;
      r_cap_pending <= 1'b0;
      r_cap_data    <= '0;
      r_ob_wr       <= '0;
      r_ob_rd       <= '0;
      r_ob_cnt      <= '0;
      r_m_tvalid    <= 1'b0;
      r_m_tdata     <= '0;
      r_level       <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_ram_cnt     <= w_ram_cnt_nxt;
      r_s_tready    <= (w_ram_cnt_nxt < RAM_FULL);
      r_vld_pipe    <= {r_vld_pipe[RD_LAT-2:0], w_issue};
      // doutb is valid in the cycle vld_pipe's last stage is set
      r_cap_pending <= r_vld_pipe[RD_LAT-1];
      if (r_vld_pipe[RD_LAT-1]) begin
        r_cap_data <= ram_doutb;
      end
      if (r_cap_pending) begin
        r_ob_wr <= r_ob_wr + 2'(1);
      end
      r_ob_rd    <= w_ob_rd_nxt;
      r_ob_cnt   <= w_ob_cnt_nxt;
      r_m_tvalid <= (w_ob_cnt_nxt != '0);
      r_m_tdata  <= w_head;
      r_level    <= r_level + (ADDR_WIDTH+3)'(w_push) - (ADDR_WIDTH+3)'(w_pop);
    end
  end

  a_no_obuf_overflow: assert property (@(posedge clk) disable iff (!rstn)
    (4'(r_ob_cnt) + 4'(w_inflight) <= 4'(OBUF_DEPTH)));

  assign s_tready   = r_s_tready;
  assign m_tvalid   = r_m_tvalid;
  assign m_tdata    = r_m_tdata;
  assign level      = r_level;
  assign ram_dina   = s_tdata;
  assign ram_addra  = r_wr_ptr;
  assign ram_wea    = w_push;
  assign ram_ena    = w_push;
  assign ram_addrb  = r_rd_ptr;
  assign ram_enb    = w_issue;
  assign ram_regceb = 1'b1;
  assign ram_rstb   = 1'b0;

endmodule

// File: tb/tb_xpmwrap_sdpram_fifo_ctrl.sv
// tb/tb_xpmwrap_sdpram_fifo_ctrl.sv - randomized scoreboard bench for xpmwrap_sdpram_fifo_ctrl
module tb_xpmwrap_sdpram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [8:0]  level;
  logic [31:0] ram_dina;
  logic [5:0]  ram_addra;
  logic        ram_wea;
  logic        ram_ena;
  logic [5:0]  ram_addrb;
  logic        ram_enb;
  logic        ram_regceb;
  logic        ram_rstb;
  logic [31:0] ram_doutb;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  int peak  = 0;
  logic [31:0] q[$];

  xpmwrap_sdpram_fifo_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .level(level),
    .ram_dina(ram_dina), .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_ena(ram_ena),
    .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_regceb(ram_regceb), .ram_rstb(ram_rstb),
    .ram_doutb(ram_doutb)
  );

  always #5 clk = ~clk;

  // RAM with two output register stages
  logic [31:0] mem [64];
  logic [31:0] rd_s1 = '0;
  logic [31:0] rd_s2 = '0;
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) rd_s1 <= mem[ram_addrb];
    if (ram_rstb) rd_s2 <= '0;
    else if (ram_regceb) rd_s2 <= rd_s1;
  end
  assign ram_doutb = rd_s2;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: handshakes sampled mid-cycle, level must equal words accepted minus words popped
  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
    end else begin
      chk_eq("level", 64'(level), 64'(q.size()));
      if (m_tvalid && m_tready) begin
        n_pop++;
        if (q.size() != 0) begin
          chk_eq("pop_data", 64'(m_tdata), 64'(q[0]));
          void'(q.pop_front());
        end else begin
          chk_eq("pop_on_empty", 64'(m_tvalid), 64'(0));
        end
      end
      if (s_tvalid && s_tready) q.push_back(s_tdata);
      if (q.size() > peak) peak = q.size();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int bound);
    int c = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    while (q.size() != 0 && c < bound) begin
      tick();
      c++;
    end
    tick();
    chk_eq({tag, "_drained_level"}, 64'(level), 64'(0));
    chk_eq({tag, "_drained_tvalid"}, 64'(m_tvalid), 64'(0));
  endtask

  initial begin
    int sent, acc, cyc, p0, lmin, lmax, accepts;
    // Test 1: reset state and first-word latency
    repeat (3) tick();
    chk_eq("rst_s_tready", 64'(s_tready), 64'(0));
    chk_eq("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk_eq("rst_m_tdata", 64'(m_tdata), 64'(0));
    chk_eq("rst_level", 64'(level), 64'(0));
    chk_eq("ram_regceb", 64'(ram_regceb), 64'(1));
    chk_eq("ram_rstb", 64'(ram_rstb), 64'(0));
    rstn = 1'b1;
    chk_eq("rel_s_tready_low", 64'(s_tready), 64'(0));
    tick();
    chk_eq("rel_s_tready_high", 64'(s_tready), 64'(1));
    s_tvalid = 1'b1;
    s_tdata  = 32'hA5A5_0001;
    m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    chk_eq("t1_level_1", 64'(level), 64'(1));
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_eq($sformatf("t1_tvalid_e%0d", k), 64'(m_tvalid), 64'(k == 4));
    end
    chk_eq("t1_data", 64'(m_tdata), 64'(32'hA5A5_0001));
    tick();
    chk_eq("t1_level_0", 64'(level), 64'(0));
    chk_eq("t1_empty_tvalid", 64'(m_tvalid), 64'(0));
    chk_eq("t1_tdata_held", 64'(m_tdata), 64'(32'hA5A5_0001));

    // Test 2: fill to 68 with the reader stalled, then drain in order
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    sent = 0;
    s_tdata = 0;
    cyc = 0;
    while (sent < 68 && cyc < 300) begin
      acc = int'(s_tvalid && s_tready);
      tick();
      cyc++;
      if (acc != 0) begin
        sent++;
        s_tdata = 32'(sent);
      end
    end
    s_tvalid = 1'b0;
    chk_eq("t2_sent", 64'(sent), 64'(68));
    repeat (10) tick();
    chk_eq("t2_full_s_tready", 64'(s_tready), 64'(0));
    chk_eq("t2_full_level", 64'(level), 64'(68));
    p0 = n_pop;
    drain("t2", 300);
    chk_eq("t2_pop_count", 64'(n_pop - p0), 64'(68));
    chk_eq("t2_last_held", 64'(m_tdata), 64'(67));

    // Test 3: continuous push and pop at full rate
    s_tvalid = 1'b1;
    s_tdata  = $urandom;
    m_tready = 1'b1;
    sent = 0;
    p0 = 0;
    lmin = 1000;
    lmax = 0;
    for (int c = 0; c < 1100 && sent < 1000; c++) begin
      acc = int'(s_tvalid && s_tready);
      tick();
      if (acc != 0) begin
        sent++;
        s_tdata = $urandom;
      end
      if (c == 20) p0 = n_pop;
      if (c >= 20 && c < 520) begin
        if (q.size() < lmin) lmin = q.size();
        if (q.size() > lmax) lmax = q.size();
      end
      if (c == 520) chk_eq("t3_rate", 64'(n_pop - p0), 64'(500));
    end
    chk_eq("t3_level_stable", 64'(lmax - lmin), 64'(0));
    chk_eq("t3_sent", 64'(sent), 64'(1000));
    drain("t3", 200);

    // Test 4: random valid/ready, 10k words across many pointer wraps
    peak = 0;
    sent = 0;
    s_tvalid = 1'b0;
    cyc = 0;
    while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
      acc = int'(s_tvalid && s_tready);
      tick();
      cyc++;
      if (acc != 0) sent++;
      if (!s_tvalid || acc != 0) begin
        if (sent < 10000) begin
          s_tvalid = 1'($urandom % 2);
          s_tdata  = $urandom;
        end else begin
          s_tvalid = 1'b0;
        end
      end
      m_tready = 1'($urandom % 2);
    end
    chk_eq("t4_sent", 64'(sent), 64'(10000));
    chk_eq("t4_peak_le_68", 64'(peak <= 68), 64'(1));
    drain("t4", 200);

    // Test 5: reset mid-stream discards everything
    m_tready = 1'b0;
    sent = 0;
    s_tvalid = 1'b1;
    s_tdata = 32'hBAD0_0000;
    for (int c = 0; c < 40 && sent < 10; c++) begin
      acc = int'(s_tvalid && s_tready);
      tick();
      if (acc != 0) begin
        sent++;
        s_tdata = 32'hBAD0_0000 + 32'(sent);
      end
    end
    s_tvalid = 1'b0;
    rstn = 1'b0;
    #1;
    chk_eq("t5_rst_tvalid", 64'(m_tvalid), 64'(0));
    chk_eq("t5_rst_level", 64'(level), 64'(0));
    chk_eq("t5_rst_s_tready", 64'(s_tready), 64'(0));
    tick();
    rstn = 1'b1;
    tick();
    chk_eq("t5_s_tready", 64'(s_tready), 64'(1));
    s_tvalid = 1'b1;
    s_tdata  = 32'h5EED_0001;
    m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    cyc = 0;
    while (!m_tvalid && cyc < 10) begin
      tick();
      cyc++;
    end
    chk_eq("t5_first_tvalid", 64'(m_tvalid), 64'(1));
    chk_eq("t5_first_data", 64'(m_tdata), 64'(32'h5EED_0001));
    drain("t5", 50);

    // Test 6: hover at full with the reader toggling
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = $urandom;
    cyc = 0;
    while (q.size() < 68 && cyc < 300) begin
      acc = int'(s_tvalid && s_tready);
      tick();
      cyc++;
      if (acc != 0) s_tdata = $urandom;
    end
    chk_eq("t6_full_level", 64'(level), 64'(68));
    p0 = n_pop;
    accepts = 0;
    for (int c = 0; c < 200; c++) begin
      acc = int'(s_tvalid && s_tready);
      m_tready = ~m_tready;
      tick();
      if (acc != 0) begin
        accepts++;
        s_tdata = $urandom;
      end
      if (q.size() >= 68) chk_eq("t6_full_blocks", 64'(s_tready), 64'(0));
      if (q.size() < 64) chk_eq("t6_room_ready", 64'(s_tready), 64'(1));
    end
    chk_eq("t6_accepts_track_pops", 64'((n_pop - p0) - accepts <= 4 && accepts > 0), 64'(1));
    drain("t6", 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
